// File: rtl/booth_mult_arbiter_if.sv
// Request/response and multiplier-side signals of the Booth multiplier arbiter.
interface booth_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_product;
  logic                   rsp_err;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_product;
  logic                   busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_product,
    output req_ready, rsp_valid, rsp_product, rsp_err,
           mul_start, mul_a, mul_b, busy
  );

  // Requesters plus multiplier side
  modport master (
    output req_valid, req_a, req_b, mul_done, mul_product,
    input  req_ready, rsp_valid, rsp_product, rsp_err,
           mul_start, mul_a, mul_b, busy
  );
endinterface

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among N_REQ
// requesters, with a per-transaction watchdog.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | arbitrate; winner gets req_ready, operands are latched
// START     | mul_start already high; watchdog counter cleared
// WAIT_DONE | waiting for mul_done or watchdog expiry
// RESP      | one-cycle rsp_valid to the granted requester
// RELEASE   | mul_start low; wait for the multiplier to drop mul_done
module booth_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst_n,
  booth_mult_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    RESP,
    RELEASE
  } state_t;

  state_t             state, state_next;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      grant;
  logic [PW-1:0]      win;
  logic               any_req;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               start_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod_q;
  logic               err_q;
  logic               timeout_hit;
  logic [N_REQ-1:0]   ready_c;
  logic [N_REQ-1:0]   rsp_c;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  // Round-robin pick: first valid requester at or above the pointer, wrapping.
  // Scanning from the far end lets the nearest candidate overwrite the rest.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
        win     = PW'((int'(ptr) + k) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

  // Next-state decode and the combinational grant pulse.
  always_comb begin
    state_next = state;
    ready_c    = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          ready_c[win] = 1'b1;
          state_next   = START;
        end
      end
      START:     state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.mul_done || timeout_hit) state_next = RESP;
      end
      RESP:      state_next = RELEASE;
      RELEASE: begin
        if (!bus.mul_done) state_next = IDLE;
      end
      default:   state_next = IDLE;
    endcase
  end

  // One-hot response strobe decoded from the stored grant.
  always_comb begin
    rsp_c = '0;
    if (state == RESP) rsp_c[grant] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath: operand capture, start control, watchdog and result capture.
  // mul_start is set on the grant edge so it is already high during START,
  // and cleared on leaving RESP so the multiplier sees it low in RELEASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      grant   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      cnt     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a_q     <= bus.req_a[int'(win)*WIDTH +: WIDTH];
            b_q     <= bus.req_b[int'(win)*WIDTH +: WIDTH];
            grant   <= win;
            ptr     <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
            start_q <= 1'b1;
          end
        end
        START: cnt <= '0;
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (bus.mul_done) begin
            prod_q <= bus.mul_product;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            prod_q <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP:    start_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = ready_c;
  assign bus.rsp_valid   = rsp_c;
  assign bus.rsp_product = prod_q;
  assign bus.rsp_err     = err_q;
  assign bus.mul_start   = start_q;
  assign bus.mul_a       = a_q;
  assign bus.mul_b       = b_q;
  assign bus.busy        = (state != IDLE);

endmodule
